// File: rtl/br_alu_sequencer.sv
// Command sequencer: buffers register-to-register ALU commands in a FIFO and runs each
// through READ -> EXEC -> WRITE against an external register bank and ALU.
module br_alu_sequencer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned OPW   = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [OPW-1:0] cmd_op,
    input  logic [4:0]     cmd_rs,
    input  logic [4:0]     cmd_rt,
    input  logic [4:0]     cmd_rd,
    output logic [4:0]     br_ar1,
    output logic [4:0]     br_ar2,
    output logic [4:0]     br_aw,
    output logic [31:0]    br_data_in,
    output logic           br_we,
    input  logic [31:0]    br_dr1,
    input  logic [31:0]    br_dr2,
    output logic [31:0]    alu_a,
    output logic [31:0]    alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [31:0]    alu_result,
    input  logic           alu_zero,
    output logic           done_valid,
    output logic [4:0]     done_rd,
    output logic           done_zero,
    output logic           busy
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PtrOne    = AW'(1);
    localparam logic [AW:0]   CntOne    = (AW + 1)'(1);
    localparam logic [AW:0]   FullCount = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StRead, StExec, StWrite} state_e;

    state_e state_q, state_d;

    logic [OPW-1:0] fifo_op [DEPTH];
    logic [4:0]     fifo_rs [DEPTH];
    logic [4:0]     fifo_rt [DEPTH];
    logic [4:0]     fifo_rd [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]    count_q;
    logic           full, empty, push, pop;

    logic [OPW-1:0] cur_op_q;
    logic [4:0]     cur_rs_q, cur_rt_q, cur_rd_q;
    logic [31:0]    op_a_q, op_b_q, res_q;
    logic           zflag_q;

    assign full  = (count_q == FullCount);
    assign empty = (count_q == '0);
    // No pop-through: a full FIFO refuses the push even when a pop happens this cycle.
    assign push  = cmd_valid && !full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_op[i] <= '0;
                fifo_rs[i] <= '0;
                fifo_rt[i] <= '0;
                fifo_rd[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_op[wr_ptr_q] <= cmd_op;
                fifo_rs[wr_ptr_q] <= cmd_rs;
                fifo_rt[wr_ptr_q] <= cmd_rt;
                fifo_rd[wr_ptr_q] <= cmd_rd;
                wr_ptr_q          <= wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CntOne;
                2'b01:   count_q <= count_q - CntOne;
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    state_d = StRead;
                    pop     = 1'b1;
                end
            end
            StRead:  state_d = StExec;
            StExec:  state_d = StWrite;
            StWrite: begin
                if (!empty) begin
                    state_d = StRead;
                    pop     = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cur_op_q <= '0;
            cur_rs_q <= '0;
            cur_rt_q <= '0;
            cur_rd_q <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            res_q    <= '0;
            zflag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                cur_op_q <= fifo_op[rd_ptr_q];
                cur_rs_q <= fifo_rs[rd_ptr_q];
                cur_rt_q <= fifo_rt[rd_ptr_q];
                cur_rd_q <= fifo_rd[rd_ptr_q];
            end
            if (state_q == StRead) begin
                op_a_q <= br_dr1;
                op_b_q <= br_dr2;
            end
            if (state_q == StExec) begin
                res_q   <= alu_result;
                zflag_q <= alu_zero;
            end
        end
    end

    assign cmd_ready  = !full;
    assign br_ar1     = cur_rs_q;
    assign br_ar2     = cur_rt_q;
    assign br_aw      = cur_rd_q;
    assign br_data_in = res_q;
    assign alu_a      = op_a_q;
    assign alu_b      = op_b_q;
    assign alu_op     = cur_op_q;
    assign done_rd    = cur_rd_q;
    assign done_zero  = zflag_q;
    // r0 is hard-wired zero in the bank, so its write enable is suppressed here.
    assign br_we      = (state_q == StWrite) && (cur_rd_q != 5'd0);
    assign done_valid = (state_q == StWrite);
    assign busy       = (state_q != StIdle) || !empty;

endmodule

// File: tb/tb_br_alu_sequencer.sv
// Directed bench for br_alu_sequencer with a behavioural register bank and a two-op ALU.
module tb_br_alu_sequencer;
    localparam int DEPTH = 4;
    localparam logic [3:0] OpAdd = 4'd0;
    localparam logic [3:0] OpSub = 4'd1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [3:0]  cmd_op;
    logic [4:0]  cmd_rs, cmd_rt, cmd_rd;
    logic [4:0]  br_ar1, br_ar2, br_aw;
    logic [31:0] br_data_in, br_dr1, br_dr2;
    logic        br_we;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_op;
    logic        alu_zero;
    logic        done_valid, done_zero, busy;
    logic [4:0]  done_rd;

    br_alu_sequencer #(.DEPTH(DEPTH), .OPW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
        .br_ar1(br_ar1), .br_ar2(br_ar2), .br_aw(br_aw), .br_data_in(br_data_in),
        .br_we(br_we), .br_dr1(br_dr1), .br_dr2(br_dr2),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .done_valid(done_valid), .done_rd(done_rd), .done_zero(done_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    // Bank model: combinational reads, write on rising edge; a bench port preloads values.
    bit [31:0]   bank [32];
    logic        tb_we = 1'b0;
    logic [4:0]  tb_wa = '0;
    logic [31:0] tb_wd = '0;
    assign br_dr1 = bank[br_ar1];
    assign br_dr2 = bank[br_ar2];
    always @(posedge clk) begin
        if (br_we) bank[br_aw] <= br_data_in;
        if (tb_we) bank[tb_wa] <= tb_wd;
    end

    always_comb begin
        alu_result = alu_a & alu_b;
        case (alu_op)
            OpAdd:   alu_result = alu_a + alu_b;
            OpSub:   alu_result = alu_a - alu_b;
            default: alu_result = alu_a & alu_b;
        endcase
    end
    assign alu_zero = (alu_result == 32'd0);

    typedef struct {
        logic [4:0]  rd;
        logic [4:0]  aw;
        logic        z;
        logic        we;
        logic [31:0] data;
        int          cyc;
    } done_t;

    done_t dq[$];
    int    cyc = 0;
    int    we_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (br_we) we_cnt <= we_cnt + 1;
        if (done_valid)
            dq.push_back('{rd: done_rd, aw: br_aw, z: done_zero, we: br_we,
                           data: br_data_in, cyc: cyc});
    end

    int n_checks = 0;
    int n_pass   = 0;
    int push_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        tb_we = 1'b1; tb_wa = a; tb_wd = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    // Leaves cmd_valid high; the caller drops it once the burst is over.
    task automatic push(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd);
        int waited = 0;
        cmd_op = op; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd; cmd_valid = 1'b1;
        while (!cmd_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) check("push_timeout", 32'd0, 32'd1);
        @(negedge clk);
        push_cyc = cyc;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (dq.size() < target && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (dq.size() < target) check("done_timeout", dq.size(), target);
    endtask

    logic [3:0]  f_op  [6] = '{OpAdd, OpSub, OpAdd, OpSub, OpAdd, OpAdd};
    logic [4:0]  f_rs  [6] = '{5'd1, 5'd10, 5'd10, 5'd1, 5'd11, 5'd12};
    logic [4:0]  f_rt  [6] = '{5'd2, 5'd10, 5'd1, 5'd2, 5'd11, 5'd2};
    logic [4:0]  f_rd  [6] = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};
    logic [31:0] f_res [6] = '{32'd12, 32'd0, 32'd17, 32'hFFFF_FFFE, 32'd0, 32'd24};
    logic        f_z   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int base, wb;
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_op = '0; cmd_rs = '0; cmd_rt = '0; cmd_rd = '0;

        // Reset state with random inputs
        repeat (4) begin
            @(negedge clk);
            cmd_valid = 1'($urandom); cmd_op = 4'($urandom);
            cmd_rs = 5'($urandom); cmd_rt = 5'($urandom); cmd_rd = 5'($urandom);
        end
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_br_we", br_we, 0);
        check("rst_done_valid", done_valid, 0);
        check("rst_addrs", {br_ar1, br_ar2, br_aw, done_rd}, 0);
        check("rst_data_in", br_data_in, 0);
        check("rst_alu_ab", alu_a | alu_b, 0);
        check("rst_alu_op_zero", {alu_op, done_zero}, 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        rst_n = 1'b1;
        preload(5'd1, 32'd5);
        preload(5'd2, 32'd7);

        // Single add: r3 = r1 + r2
        base = dq.size();
        push(OpAdd, 5'd1, 5'd2, 5'd3);
        cmd_valid = 1'b0;
        wait_done(base + 1);
        check("add_latency", dq[base].cyc - push_cyc, 3);
        check("add_we", dq[base].we, 1);
        check("add_aw", dq[base].aw, 3);
        check("add_data", dq[base].data, 12);
        repeat (3) @(negedge clk);
        #1;
        check("add_single_pulse", dq.size(), base + 1);
        check("add_r3", bank[3], 12);
        check("add_idle_busy", busy, 0);

        // Back-to-back dependency: r3 = r1 + r2, then r4 = r3 + r3
        preload(5'd3, 32'd0);
        base = dq.size();
        push(OpAdd, 5'd1, 5'd2, 5'd3);
        push(OpAdd, 5'd3, 5'd3, 5'd4);
        cmd_valid = 1'b0;
        wait_done(base + 2);
        check("b2b_spacing", dq[base + 1].cyc - dq[base].cyc, 3);
        check("b2b_rd_order", {dq[base].rd, dq[base + 1].rd}, {5'd3, 5'd4});
        check("b2b_data", dq[base + 1].data, 24);
        @(negedge clk);
        check("b2b_r4", bank[4], 24);

        // r0 protection
        base = dq.size();
        wb = we_cnt;
        push(OpAdd, 5'd1, 5'd2, 5'd0);
        cmd_valid = 1'b0;
        wait_done(base + 1);
        repeat (2) @(negedge clk);
        #1;
        check("r0_done_rd", dq[base].rd, 0);
        check("r0_we_at_done", dq[base].we, 0);
        check("r0_we_count", we_cnt - wb, 0);
        check("r0_value", bank[0], 0);

        // Full FIFO, ordering and zero flag
        base = dq.size();
        for (int i = 0; i < DEPTH + 2; i++) push(f_op[i], f_rs[i], f_rt[i], f_rd[i]);
        #1;
        check("full_ready_low", cmd_ready, 0);
        check("full_busy", busy, 1);
        // An extra command held against a full FIFO must be refused.
        cmd_op = OpAdd; cmd_rs = 5'd1; cmd_rt = 5'd2; cmd_rd = 5'd31;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_done(base + DEPTH + 2);
        repeat (6) @(negedge clk);
        #1;
        check("full_count", dq.size(), base + DEPTH + 2);
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (dq.size() > base + i) begin
                check($sformatf("full_rd%0d", i), dq[base + i].rd, f_rd[i]);
                check($sformatf("full_data%0d", i), dq[base + i].data, f_res[i]);
                check($sformatf("full_zero%0d", i), dq[base + i].z, f_z[i]);
            end
        end
        check("full_r15", bank[15], 24);
        check("full_r31_untouched", bank[31], 0);

        // Mid-command reset during EXEC
        preload(5'd20, 32'hDEAD);
        base = dq.size();
        wb = we_cnt;
        push(OpAdd, 5'd1, 5'd2, 5'd20);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_exec_opa", alu_a, 5);
        rst_n = 1'b0;
        #1;
        check("mid_rst_we", br_we, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", cmd_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("mid_no_done", dq.size(), base);
        check("mid_no_we", we_cnt - wb, 0);
        check("mid_r20_kept", bank[20], 32'hDEAD);
        check("mid_busy_after", busy, 0);
        push(OpAdd, 5'd1, 5'd2, 5'd21);
        cmd_valid = 1'b0;
        wait_done(base + 1);
        check("mid_next_rd", dq[base].rd, 21);
        check("mid_next_data", dq[base].data, 12);
        @(negedge clk);
        check("mid_next_r21", bank[21], 12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/br_alu_sequencer.md
# br_alu_sequencer

Multi-cycle command sequencer that owns the register bank and the ALU. It accepts register-to-register ALU commands (op, rs, rt, rd) through a valid/ready port and buffers them in a small FIFO. For each command it reads the two source registers, runs the ALU, and writes the result back to the bank. It sits between the command source (decoder or testbench) and the bank + ALU pair, and is the only block that drives bank addresses and the write enable.

## Interface
- DEPTH, 4: command FIFO depth; power of two, ≥2.
- OPW, 4: ALU operation code width.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_op  in  OPW  ALU operation.
- cmd_rs, cmd_rt, cmd_rd  in  5 each  source A, source B and destination register addresses.
- br_ar1, br_ar2  out  5 each  bank read addresses.
- br_aw  out  5  bank write address.
- br_data_in  out  32  bank write data.
- br_we  out  1  bank write enable.
- br_dr1, br_dr2  in  32 each  bank read data; combinational from br_ar1/br_ar2.
- alu_a, alu_b  out  32 each  ALU operands.
- alu_op  out  OPW  ALU operation.
- alu_result  in  32  ALU result; combinational.
- alu_zero  in  1  ALU zero flag.
- done_valid  out  1  one-cycle pulse when a command retires.
- done_rd  out  5  destination of the retiring command.
- done_zero  out  1  captured alu_zero of the retiring command.
- busy  out  1  state != IDLE or FIFO not empty.

## Operation
- **Push:** a command is pushed when cmd_valid && cmd_ready at the rising edge.
- **Full FIFO:** cmd_ready is low. There is no pop-through, so a push is refused even in a cycle where a pop occurs.
- **FSM states:** IDLE, READ, EXEC, WRITE.
- **IDLE:** if the FIFO is not empty, go to READ and pop the head into cur_op, cur_rs, cur_rt, cur_rd. Otherwise stay in IDLE.
- **READ:** go to EXEC. At that edge, op_a <= br_dr1 and op_b <= br_dr2.
- **EXEC:** go to WRITE. At that edge, res <= alu_result and zflag <= alu_zero.
- **WRITE:** if the FIFO is not empty, go to READ and pop the next command. Otherwise go to IDLE.
- **Output wiring (always, registered sources):**
  - br_ar1 = cur_rs, br_ar2 = cur_rt.
  - br_aw = cur_rd, br_data_in = res.
  - alu_a = op_a, alu_b = op_b, alu_op = cur_op.
  - done_rd = cur_rd, done_zero = zflag.
- **br_we:** asserted only in WRITE and only when cur_rd != 0. Register 0 is never written.
- **done_valid:** asserted in every WRITE cycle, including when cur_rd == 0.
- **Ordering:** commands retire strictly in FIFO order.
- **Read-after-write:** the next READ starts after the previous WRITE edge, so it always sees the committed value. No forwarding logic is needed.
- **Reset (asynchronous, any time including mid-command):**
  - FSM goes to IDLE, the FIFO is flushed, and all internal registers clear to 0.
  - An aborted command produces no write and no done pulse.
- **Reset values:** cmd_ready=1, busy=0, br_we=0, done_valid=0; all address, data and operand outputs are 0.

## Timing
- Command accepted at edge E0; the FIFO shows non-empty after E0.
- E1: IDLE→READ with the pop. The READ cycle runs E1–E2.
- EXEC runs E2–E3. WRITE runs E3–E4, with br_we and done_valid high in that cycle.
- Latency from acceptance to done_valid is 3 cycles. The bank commits the write during E3–E4.
- Back-to-back throughput is one command per 3 cycles, with no IDLE cycle between commands.
- FIFO pointers wrap modulo DEPTH. The count ranges 0..DEPTH.
- Simultaneous push and pop (not full): the count is unchanged.
- Push into an empty FIFO while the FSM is in WRITE: the command is not visible until the next edge. The FSM goes to IDLE for one cycle, then to READ.

## Test plan
- **Reset state:** hold rst_n=0 with random inputs → all outputs at reset values, cmd_ready=1, busy=0.
- **Single add:** preload bank r1=5, r2=7; push op=ADD, rs=1, rt=2, rd=3 at E0 → br_we=1, br_aw=3, br_data_in=12 in cycle E3–E4; done_valid for exactly 1 cycle; then r3 reads back 12.
- **Back-to-back dependency:** push (r3=r1+r2) then (r4=r3+r3) on consecutive cycles → two done pulses exactly 3 cycles apart; r4 ends at 24.
- **r0 protection:** push rd=0 with a nonzero result → br_we stays 0 throughout; done_valid still pulses with done_rd=0; r0 is unchanged.
- **Full FIFO, order and zero flag:**
  - Hold cmd_valid=1 with DEPTH+2 commands → cmd_ready drops after DEPTH pushes while the FSM holds one command.
  - All commands retire in order with none lost.
  - A subtraction producing 0 gives done_zero=1.
- **Mid-command reset:** assert rst_n=0 during EXEC → no br_we that cycle or later; FIFO empty; after release, busy=0 and the next command executes normally.
